branch_ctrl_unit: RTL and testbench
===================================

// Module: branch_ctrl_unit
// PURPOSE
//   Parametrised branch/jump resolution unit with a return-address stack (RAS).
//   Decodes conditional branch, jump, call and return instructions against the
//   ALU status flags. Issues a registered one-cycle branch request to the
//   program counter logic. Sits between the instruction register and the PC mux.
// PARAMETERS
//   ADDR_W     16  width of pc, branch_addr and RAS entries (12..32)
//   NUM_FLAGS  3   number of status flags on flags input (1..8)
//   RAS_DEPTH  8   return-address stack entries (power of 2, >=2)
// PORTS
//   clk            in   1          clock, rising edge
//   reset          in   1          asynchronous, active-high reset
//   instr_valid    in   1          instruction is present this cycle
//   instruction    in   16         [15:12] opcode, remaining fields per opcode
//   pc             in   ADDR_W     address of the current instruction
//   flags          in   NUM_FLAGS  status flags (bit0 Zero, bit1 Carry, bit2 DivDone, ...)
//   flush          in   1          synchronous RAS clear; suppresses current instr
//   branch_enable  out  1          one-cycle taken-branch pulse
//   branch_addr    out  ADDR_W     branch target; valid when branch_enable=1
//   ras_count      out  clog2(RAS_DEPTH)+1  valid RAS entries
//   ras_overflow   out  1          sticky: CALL issued with RAS full
//   ras_underflow  out  1          sticky: RET issued with RAS empty
// BEHAVIOUR
//   Reset: all outputs 0, RAS pointer and count 0. RAS contents are don't-care.
//   Latency: all outputs are registered; the decision for the instr at edge N appears after edge N.
//   branch_enable is high for exactly one cycle per taken instr. It is 0 when instr_valid=0.
//   branch_addr holds its last value when not taken.
//   Opcodes (acted on only when instr_valid=1 and flush=0):
//     4'b1000 BCC: [11]=inv, [10:8]=flag idx, [7:0]=target, zero-extended.
//       taken = flags[idx]^inv. If idx>=NUM_FLAGS, the branch is never taken,
//       regardless of inv.
//     4'b1001 JMP: always taken; target = [11:0] zero-extended.
//     4'b1010 CALL: always taken; target = [11:0] zero-extended.
//       Push (pc+1) mod 2^ADDR_W onto the RAS.
//     4'b1011 RET: if ras_count>0, taken; target = top entry; pop.
//       If empty: not taken, branch_addr unchanged, ras_underflow<=1, count stays 0.
//     Any other opcode: branch_enable<=0, RAS unchanged.
//   RAS is a circular buffer with a top pointer that wraps mod RAS_DEPTH.
//     Push: ptr+1, then write. count = min(count+1, RAS_DEPTH).
//     Full push: overwrite the oldest entry, set ras_overflow<=1; the branch is still taken.
//     Pop: read the entry at ptr, then ptr-1 and count-1.
//     Deep returns after an overflow return the surviving newest entries only.
//   flush=1: count<=0, ptr<=0, both sticky flags<=0, branch_enable<=0.
//     The current instr is ignored, even if valid. flush wins over any opcode.
//   Reset asserted mid-operation clears state immediately (async).
//     No pending branch survives reset.
//   Sticky flags clear only on reset or flush.
// TESTING
//   1 BCC 0x8005 (inv=0, idx=0), flags=3'b001 -> next cycle enable=1, addr=0x0005.
//     Same with flags=0 -> enable=0.
//   2 BCC 0x8805 (inv=1, idx=0), flags=0 -> enable=1, addr=0x0005.
//     idx=5 with NUM_FLAGS=3 -> enable=0 for any inv.
//   3 CALL 0xA123 at pc=0x0040, then RET 0xB000 -> enable=1 with addr=0x0123, then
//     enable=1 with addr=0x0041, ras_count 1 then 0.
//   4 RET with empty RAS -> enable=0, ras_underflow=1, branch_addr unchanged.
//     A flush then clears ras_underflow.
//   5 9 CALLs at pc=0x10..0x18 (RAS_DEPTH=8) -> ras_overflow=1, count=8.
//     8 RETs return 0x19..0x12 in order; a 9th RET sets ras_underflow.
//   6 JMP 0x9ABC with flush=1 in the same cycle -> enable=0, count=0.
//     Reset asserted mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/branch_ctrl_unit.sv
// Branch/jump resolution unit with a circular return-address stack.
// Decodes BCC/JMP/CALL/RET against status flags and issues a registered one-cycle branch request.
module branch_ctrl_unit #(
    parameter int ADDR_W    = 16,
    parameter int NUM_FLAGS = 3,
    parameter int RAS_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           instr_valid,
    input  logic [15:0]                    instruction,
    input  logic [ADDR_W-1:0]              pc,
    input  logic [NUM_FLAGS-1:0]           flags,
    input  logic                           flush,
    output logic                           branch_enable,
    output logic [ADDR_W-1:0]              branch_addr,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_overflow,
    output logic                           ras_underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [3:0] OP_BCC  = 4'b1000;
    localparam logic [3:0] OP_JMP  = 4'b1001;
    localparam logic [3:0] OP_CALL = 4'b1010;
    localparam logic [3:0] OP_RET  = 4'b1011;

    // Occupancy saturates at the stack depth; a full push overwrites the oldest entry.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_W'(RAS_DEPTH)) ? c : c + CNT_W'(1);
    endfunction

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_ptr;

    logic [3:0]        opcode_p0;
    logic [2:0]        bcc_idx_p0;
    logic              bcc_inv_p0;
    logic              idx_ok_p0;
    logic              flag_sel_p0;
    logic              act_p0;
    logic              take_p0;
    logic [ADDR_W-1:0] target_p0;
    logic              do_push_p0;
    logic              do_pop_p0;
    logic              underflow_p0;
    logic              ras_full_p0;
    logic [ADDR_W-1:0] pc_inc_p0;

    assign opcode_p0   = instruction[15:12];
    assign bcc_inv_p0  = instruction[11];
    assign bcc_idx_p0  = instruction[10:8];
    assign idx_ok_p0   = ({29'd0, bcc_idx_p0} < 32'(NUM_FLAGS));
    assign act_p0      = instr_valid & ~flush;
    assign ras_full_p0 = (ras_count == CNT_W'(RAS_DEPTH));
    assign pc_inc_p0   = pc + ADDR_W'(1);

    // Stage p0: decode and resolve the branch combinationally
    always_comb begin
        flag_sel_p0  = 1'b0;
        take_p0      = 1'b0;
        target_p0    = '0;
        do_push_p0   = 1'b0;
        do_pop_p0    = 1'b0;
        underflow_p0 = 1'b0;
        for (int i = 0; i < NUM_FLAGS; i++) begin
            if (bcc_idx_p0 == 3'(i)) flag_sel_p0 = flags[i];
        end
        if (act_p0) begin
            case (opcode_p0)
                OP_BCC: begin
                    take_p0   = idx_ok_p0 & (flag_sel_p0 ^ bcc_inv_p0);
                    target_p0 = ADDR_W'(instruction[7:0]);
                end
                OP_JMP: begin
                    take_p0   = 1'b1;
                    target_p0 = ADDR_W'(instruction[11:0]);
                end
                OP_CALL: begin
                    take_p0    = 1'b1;
                    target_p0  = ADDR_W'(instruction[11:0]);
                    do_push_p0 = 1'b1;
                end
                OP_RET: begin
                    if (ras_count != '0) begin
                        take_p0   = 1'b1;
                        target_p0 = ras_mem[ras_ptr];
                        do_pop_p0 = 1'b1;
                    end else begin
                        underflow_p0 = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage p1: registered branch request and stack control
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_enable <= 1'b0;
            branch_addr   <= '0;
            ras_count     <= '0;
            ras_ptr       <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else if (flush) begin
            branch_enable <= 1'b0;
            ras_count     <= '0;
            ras_ptr       <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            branch_enable <= take_p0;
            if (take_p0) branch_addr <= target_p0;
            if (do_push_p0) begin
                ras_ptr   <= ras_ptr + PTR_W'(1);
                ras_count <= sat_inc(ras_count);
                if (ras_full_p0) ras_overflow <= 1'b1;
            end
            if (do_pop_p0) begin
                ras_ptr   <= ras_ptr - PTR_W'(1);
                ras_count <= ras_count - CNT_W'(1);
            end
            if (underflow_p0) ras_underflow <= 1'b1;
        end
    end

    // Stack storage is data only: no reset, pointer-relative write of the return address
    always_ff @(posedge clk) begin
        if (do_push_p0) ras_mem[ras_ptr + PTR_W'(1)] <= pc_inc_p0;
    end

endmodule

// File: tb/tb_branch_ctrl_unit.sv
// Directed-vector bench for branch_ctrl_unit with hand-computed expectations.
module tb_branch_ctrl_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instruction;
    logic [15:0] pc;
    logic [2:0]  flags;
    logic        flush;
    logic        branch_enable;
    logic [15:0] branch_addr;
    logic [3:0]  ras_count;
    logic        ras_overflow;
    logic        ras_underflow;

    int n_vec = 0;
    int n_err = 0;

    branch_ctrl_unit #(.ADDR_W(16), .NUM_FLAGS(3), .RAS_DEPTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .instruction   (instruction),
        .pc            (pc),
        .flags         (flags),
        .flush         (flush),
        .branch_enable (branch_enable),
        .branch_addr   (branch_addr),
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one instruction for exactly one rising edge, then sample 1 ns after it.
    task automatic step(input logic v, input logic [15:0] ins, input logic [15:0] p,
                        input logic [2:0] f, input logic fl);
        @(negedge clk);
        instr_valid = v;
        instruction = ins;
        pc          = p;
        flags       = f;
        flush       = fl;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic en, input logic [15:0] addr,
                           input logic [3:0] cnt);
        chk({tag, ".en"},   32'(branch_enable), 32'(en));
        chk({tag, ".addr"}, 32'(branch_addr),   32'(addr));
        chk({tag, ".cnt"},  32'(ras_count),     32'(cnt));
    endtask

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instruction = '0; pc = '0; flags = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_out("rst", 1'b0, 16'h0000, 4'd0);
        chk("rst.ovf", 32'(ras_overflow), 0);
        chk("rst.unf", 32'(ras_underflow), 0);
        @(negedge clk);
        reset = 1'b0;

        // BCC on Zero, plain and inverted, plus out-of-range flag index
        step(1, 16'h8005, 16'h0000, 3'b001, 0); chk_out("bcc_z1", 1, 16'h0005, 0);
        step(1, 16'h8005, 16'h0000, 3'b000, 0); chk_out("bcc_z0", 0, 16'h0005, 0);
        step(1, 16'h8805, 16'h0000, 3'b000, 0); chk_out("bcc_inv", 1, 16'h0005, 0);
        step(1, 16'h9ABC, 16'h0000, 3'b000, 0); chk_out("jmp", 1, 16'h0ABC, 0);
        step(1, 16'h8505, 16'h0000, 3'b111, 0); chk_out("bcc_i5", 0, 16'h0ABC, 0);
        step(1, 16'h8D05, 16'h0000, 3'b000, 0); chk_out("bcc_i5inv", 0, 16'h0ABC, 0);
        step(1, 16'h8277, 16'h0000, 3'b100, 0); chk_out("bcc_i2", 1, 16'h0077, 0);
        step(0, 16'h9123, 16'h0000, 3'b000, 0); chk_out("novalid", 0, 16'h0077, 0);
        step(1, 16'h3123, 16'h0000, 3'b111, 0); chk_out("otherop", 0, 16'h0077, 0);

        // CALL / RET round trip
        step(1, 16'hA123, 16'h0040, 3'b000, 0); chk_out("call", 1, 16'h0123, 1);
        step(1, 16'hB000, 16'h0000, 3'b000, 0); chk_out("ret", 1, 16'h0041, 0);

        // RET on empty stack, then flush clears the sticky flag
        step(1, 16'hB000, 16'h0000, 3'b000, 0); chk_out("ret_empty", 0, 16'h0041, 0);
        chk("ret_empty.unf", 32'(ras_underflow), 1);
        step(0, 16'h0000, 16'h0000, 3'b000, 1);
        chk("flush.unf", 32'(ras_underflow), 0);

        // Return address wraps at the top of the address space
        step(1, 16'hA010, 16'hFFFF, 3'b000, 0); chk_out("call_wrap", 1, 16'h0010, 1);
        step(1, 16'hB000, 16'h0000, 3'b000, 0); chk_out("ret_wrap", 1, 16'h0000, 0);

        // Nine CALLs overflow an 8-deep stack; oldest return address is lost
        for (int i = 0; i < 9; i++) begin
            step(1, 16'hA200 + 16'(i), 16'h0010 + 16'(i), 3'b000, 0);
            chk($sformatf("call%0d.addr", i), 32'(branch_addr), 32'h0200 + i);
            chk($sformatf("call%0d.ovf", i), 32'(ras_overflow), (i == 8) ? 1 : 0);
        end
        chk("ovf.cnt", 32'(ras_count), 8);
        for (int i = 0; i < 8; i++) begin
            step(1, 16'hB000, 16'h0000, 3'b000, 0);
            chk_out($sformatf("deep_ret%0d", i), 1, 16'h0019 - 16'(i), 4'(7 - i));
        end
        step(1, 16'hB000, 16'h0000, 3'b000, 0); chk_out("ret9", 0, 16'h0012, 0);
        chk("ret9.unf", 32'(ras_underflow), 1);
        chk("ret9.ovf", 32'(ras_overflow), 1);

        // flush wins over a JMP in the same cycle
        step(1, 16'hA001, 16'h0100, 3'b000, 0); chk_out("pre_flush", 1, 16'h0001, 1);
        step(1, 16'h9ABC, 16'h0000, 3'b000, 1); chk_out("jmp_flush", 0, 16'h0001, 0);
        chk("jmp_flush.ovf", 32'(ras_overflow), 0);
        chk("jmp_flush.unf", 32'(ras_underflow), 0);

        // Asynchronous reset mid-burst clears outputs before the next edge
        step(1, 16'hA055, 16'h0200, 3'b000, 0); chk_out("burst", 1, 16'h0055, 1);
        #2 reset = 1'b1;
        #1 chk_out("async_rst", 0, 16'h0000, 0);
        // A valid JMP presented under reset must not produce a branch
        @(negedge clk);
        instr_valid = 1'b1; instruction = 16'h9ABC;
        @(posedge clk);
        #1;
        chk_out("rst_hold", 0, 16'h0000, 0);
        instr_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        step(1, 16'h9ABC, 16'h0000, 3'b000, 0); chk_out("post_rst", 1, 16'h0ABC, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
